// File: rtl/mips_single_cycle_datapath.sv
// Single-cycle 32-bit MIPS core: PC, instruction memory, register file,
// ALU, data memory and main control. One instruction retires per rising edge.

// 32x32 register file, two combinational read ports, one edge-written port.
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [0:31];

  // Clear every register on reset; register 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) RF[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      RF[wa] <= wd;
    end
  end

  // Read ports see pre-edge contents; register 0 is hard-wired to zero.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];
  end
endmodule

// 1024-word memory indexed directly by byte address; out-of-range reads
// return zero and out-of-range writes are dropped. Used for both the
// instruction memory (write port tied off, contents preloaded externally)
// and the data memory.
module mips_mem (
  input  logic        clk,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);
  logic [31:0] ram [0:1023];

  // Edge-triggered write, only when the address lands inside the array.
  always_ff @(posedge clk) begin
    if (we && (waddr < 32'd1024)) ram[waddr[9:0]] <= wdata;
  end

  // Combinational read with zero for addresses past the end.
  always_comb begin
    rdata = (raddr < 32'd1024) ? ram[raddr[9:0]] : '0;
  end
endmodule

module mips_single_cycle_datapath (
  input logic clk,
  input logic Reset
);
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext, pc_plus4, branch_target, jump_target, next_pc;
  logic [31:0] rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
  logic [4:0]  wb_addr;
  logic        reg_we, reg_dst_rd, alu_src_imm, mem_to_reg, mem_we;
  logic        is_beq, is_j;
  alu_op_t     alu_op;

  mips_mem instMem (
    .clk   (clk),
    .raddr (pc),
    .rdata (instr),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0)
  );

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];
  assign sext   = {{16{imm[15]}}, imm};

  // Main control: unknown opcodes and unknown R-type functs write nothing.
  always_comb begin
    reg_we      = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    mem_we      = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    alu_op      = ALU_ADD;
    unique case (op)
      6'h00: begin
        reg_dst_rd = 1'b1;
        reg_we     = 1'b1;
        unique case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          6'h00:   alu_op = ALU_SLL;
          6'h02:   alu_op = ALU_SRL;
          default: reg_we = 1'b0;
        endcase
      end
      6'h08: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
      end
      6'h23: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      6'h2B: begin
        alu_src_imm = 1'b1;
        mem_we      = 1'b1;
      end
      6'h04:   is_beq = 1'b1;
      6'h02:   is_j   = 1'b1;
      default: ;
    endcase
  end

  assign wb_addr = reg_dst_rd ? rd : rt;

  mips_regfile rf (
    .clk   (clk),
    .rst_n (Reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wb_addr),
    .wd    (wb_data),
    .we    (reg_we),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  assign alu_b = alu_src_imm ? sext : rt_val;

  // ALU: wrap-around arithmetic, shifts take rt and shamt.
  always_comb begin
    alu_y = '0;
    unique case (alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_y = alu_b << shamt;
      ALU_SRL: alu_y = alu_b >> shamt;
      default: alu_y = '0;
    endcase
  end

  // Store enable is gated by reset so a held reset never touches memory.
  mips_mem dataMem (
    .clk   (clk),
    .raddr (alu_y),
    .rdata (mem_rdata),
    .we    (mem_we && Reset),
    .waddr (alu_y),
    .wdata (rt_val)
  );

  assign wb_data = mem_to_reg ? mem_rdata : alu_y;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], target, 2'b00};

  // Next-PC select: jump, taken branch, or sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (is_j)                             next_pc = jump_target;
    else if (is_beq && (rs_val == rt_val)) next_pc = branch_target;
  end

  // Program counter with asynchronous clear.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) pc <= '0;
    else        pc <= next_pc;
  end
endmodule

// File: tb/tb_mips_single_cycle_datapath.sv
// Program-level bench for the single-cycle MIPS core: each test loads a
// program, queues the expected architectural state, runs a fixed number of
// edges and pops the expectations against the state it then observes.
module tb_mips_single_cycle_datapath;
  logic clk = 1'b0;
  logic Reset = 1'b0;

  mips_single_cycle_datapath dut (.clk(clk), .Reset(Reset));

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];
  logic [31:0] prog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", got, 32'hDEAD_BEEF);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  // Reset the core between edges, load prog at address 0, then release.
  task automatic start_prog();
    @(negedge clk);
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.instMem.ram[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.instMem.ram[4*i] = prog[i];
    Reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset behaviour: reach pc=40 with RF[8]=5, then async reset.
    prog = '{32'h20080005, 32'h0800000A};
    start_prog();
    sb_push("pre_pc", 32'd40);
    sb_push("pre_t0", 32'd5);
    run(2);
    sb_pop(dut.pc);
    sb_pop(dut.rf.RF[8]);
    Reset = 1'b0;
    #1;
    sb_push("rst_pc", 32'd0);
    for (int i = 0; i < 32; i++) sb_push($sformatf("rst_rf%0d", i), 32'd0);
    sb_pop(dut.pc);
    for (int i = 0; i < 32; i++) sb_pop(dut.rf.RF[i]);
    sb_push("hold_pc", 32'd0);
    sb_push("hold_t0", 32'd0);
    run(3);
    sb_pop(dut.pc);
    sb_pop(dut.rf.RF[8]);

    // Jump and ALU program (setup addi prefix, jump retargeted to 20).
    prog = '{32'h2008007B, 32'h200AFFF6, 32'h00004820, 32'h08000005,
             32'h014A5020, 32'h012A5822, 32'h00086880, 32'h0148702A};
    start_prog();
    sb_push("j_pc", 32'd20);
    run(4);
    sb_pop(dut.pc);
    sb_push("alu_t1", 32'd0);
    sb_push("alu_t2", 32'hFFFFFFF6);
    sb_push("alu_t3", 32'd10);
    sb_push("alu_t5", 32'd492);
    sb_push("alu_t6", 32'd1);
    sb_push("alu_pc", 32'd32);
    run(3);
    sb_pop(dut.rf.RF[9]);
    sb_pop(dut.rf.RF[10]);
    sb_pop(dut.rf.RF[11]);
    sb_pop(dut.rf.RF[13]);
    sb_pop(dut.rf.RF[14]);
    sb_pop(dut.pc);

    // Load/store, dependent use after lw, out-of-range store and load.
    prog = '{32'h20080008, 32'h2009FFF9, 32'hAD090004, 32'h8D0A0004,
             32'h014A6820, 32'h200B0400, 32'hAD690000, 32'h8D6C0000};
    start_prog();
    sb_push("sw_mem12", 32'hFFFFFFF9);
    sb_push("lw_t2", 32'hFFFFFFF9);
    run(4);
    sb_pop(dut.dataMem.ram[12]);
    sb_pop(dut.rf.RF[10]);
    sb_push("lwuse_t5", 32'hFFFFFFF2);
    sb_push("lw_oob_t4", 32'd0);
    sb_push("ls_pc", 32'd32);
    run(4);
    sb_pop(dut.rf.RF[13]);
    sb_pop(dut.rf.RF[12]);
    sb_pop(dut.pc);

    // beq taken with imm=-1 spins at 8; not taken falls through to 12.
    prog = '{32'h20080003, 32'h20090003, 32'h1109FFFF};
    start_prog();
    sb_push("beq_t_pc1", 32'd8);
    sb_push("beq_t_pc2", 32'd8);
    run(3);
    sb_pop(dut.pc);
    run(1);
    sb_pop(dut.pc);
    prog = '{32'h20080003, 32'h20090004, 32'h1109FFFF};
    start_prog();
    sb_push("beq_nt_pc", 32'd12);
    run(3);
    sb_pop(dut.pc);

    // $zero write, undefined opcode, unknown funct, jump past imem end.
    prog = '{32'h20080007, 32'h01080020, 32'hFD08FFFF, 32'h01084827,
             32'h08000100};
    start_prog();
    sb_push("zero_rf0", 32'd0);
    sb_push("undef_t0", 32'd7);
    sb_push("undef_pc", 32'd12);
    run(3);
    sb_pop(dut.rf.RF[0]);
    sb_pop(dut.rf.RF[8]);
    sb_pop(dut.pc);
    sb_push("badfn_t1", 32'd0);
    sb_push("oob_pc", 32'd1028);
    sb_push("oob_t0", 32'd7);
    run(3);
    sb_pop(dut.rf.RF[9]);
    sb_pop(dut.pc);
    sb_pop(dut.rf.RF[8]);

    // Overflow wrap and logical shift right of the sign bit.
    prog = '{32'h2008FFFF, 32'h00084042, 32'h01084820, 32'h200A0001,
             32'h000A57C0, 32'h000A5FC2, 32'h010A6024, 32'h010A6825};
    start_prog();
    sb_push("wrap_t0", 32'h7FFFFFFF);
    sb_push("wrap_t1", 32'hFFFFFFFE);
    sb_push("sll31_t2", 32'h80000000);
    sb_push("srl31_t3", 32'd1);
    sb_push("and_t4", 32'd0);
    sb_push("or_t5", 32'hFFFFFFFF);
    run(8);
    sb_pop(dut.rf.RF[8]);
    sb_pop(dut.rf.RF[9]);
    sb_pop(dut.rf.RF[10]);
    sb_pop(dut.rf.RF[11]);
    sb_pop(dut.rf.RF[12]);
    sb_pop(dut.rf.RF[13]);

    if (sb_q.size() != 0) chk("scoreboard_leftover", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
